// File: rtl/led_mode_sequencer.sv
// Single-button LED mode sequencer: a short press steps the blink rate, a long press
// toggles blinking on/off. The raw button is synchronized and debounced before use.
module led_mode_sequencer #(
  parameter int         DEBOUNCE_CYCLES   = 16,
  parameter int         LONG_PRESS_CYCLES = 256,
  parameter logic [3:0] MIN_RATE          = 4'd0,
  parameter logic [3:0] MAX_RATE          = 4'd15,
  parameter logic [3:0] RESET_RATE        = 4'd4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn,
  output logic       o_enable,
  output logic [3:0] o_blink_rate,
  output logic       o_short_pulse,
  output logic       o_long_pulse
);

  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] LONG_LAST = 16'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  state_t      state;
  logic        btn_meta_p0;
  logic        btn_sync;
  logic        btn_stable;
  logic [15:0] deb_cnt;
  logic [15:0] hold_cnt;

  // Steps the rate upward; at or beyond the top it folds back to the bottom, which also
  // keeps the rate fixed when the range collapses to a single value.
  function automatic logic [3:0] step_rate(input logic [3:0] rate);
    logic [3:0] nxt;
    if (rate >= MAX_RATE) begin
      nxt = MIN_RATE;
    end else begin
      nxt = rate + 4'd1;
    end
    return nxt;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous button
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_meta_p0 <= 1'b0;
      btn_sync    <= 1'b0;
    end else begin
      btn_meta_p0 <= i_btn;
      btn_sync    <= btn_meta_p0;
    end
  end

  // Debounce: any return to the stable level restarts the count from zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_stable <= 1'b0;
      deb_cnt    <= 16'd0;
    end else if (btn_sync == btn_stable) begin
      deb_cnt <= 16'd0;
    end else if (deb_cnt == DEB_LAST) begin
      btn_stable <= btn_sync;
      deb_cnt    <= 16'd0;
    end else begin
      deb_cnt <= deb_cnt + 16'd1;
    end
  end

  // Press classifier with registered actions
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      hold_cnt      <= 16'd0;
      o_enable      <= 1'b0;
      o_blink_rate  <= RESET_RATE;
      o_short_pulse <= 1'b0;
      o_long_pulse  <= 1'b0;
    end else begin
      o_short_pulse <= 1'b0;
      o_long_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_stable) begin
            state    <= PRESSED;
            hold_cnt <= 16'd0;
          end
        end
        PRESSED: begin
          if (!btn_stable) begin
            state         <= IDLE;
            o_short_pulse <= 1'b1;
            if (o_enable) begin
              o_blink_rate <= step_rate(o_blink_rate);
            end
          end else if (hold_cnt == LONG_LAST) begin
            state        <= LONG_HELD;
            o_long_pulse <= 1'b1;
            o_enable     <= ~o_enable;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        LONG_HELD: begin
          if (!btn_stable) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
module tb_led_mode_sequencer;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       enable;
  logic [3:0] rate;
  logic       short_p;
  logic       long_p;

  int checks;
  int errors;
  int short_cnt;
  int long_cnt;
  int overlap_cnt;

  led_mode_sequencer #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_btn        (btn),
    .o_enable     (enable),
    .o_blink_rate (rate),
    .o_short_pulse(short_p),
    .o_long_pulse (long_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (short_p) short_cnt = short_cnt + 1;
    if (long_p) long_cnt = long_cnt + 1;
    if (short_p && long_p) overlap_cnt = overlap_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_btn(input int n);
    btn = 1'b1;
    repeat (n) @(negedge clk);
    btn = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    btn   = 1'b0;
    idle(3);
    checks++;
    if (enable !== 1'b0 || rate !== 4'd4 || short_p !== 1'b0 || long_p !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: en=%b rate=%0d sp=%b lp=%b, want en=0 rate=4 sp=0 lp=0",
               enable, rate, short_p, long_p);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (enable !== 1'b0 || rate !== 4'd4 || short_p !== 1'b0 || long_p !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: en=%b rate=%0d sp=%b lp=%b, want en=0 rate=4 sp=0 lp=0",
                 i, enable, rate, short_p, long_p);
      end
    end
  endtask

  task automatic test_enable;
    int s0, l0;
    s0 = short_cnt;
    l0 = long_cnt;
    hold_btn(40);
    idle(20);
    checks++;
    if (long_cnt - l0 !== 1) begin
      errors++;
      $display("FAIL enable_long_count: got %0d want 1", long_cnt - l0);
    end
    checks++;
    if (short_cnt - s0 !== 0) begin
      errors++;
      $display("FAIL enable_no_short: got %0d want 0", short_cnt - s0);
    end
    checks++;
    if (enable !== 1'b1 || rate !== 4'd4) begin
      errors++;
      $display("FAIL enable_state: en=%b rate=%0d, want en=1 rate=4", enable, rate);
    end
  endtask

  task automatic test_short;
    int s0, l0, first;
    s0 = short_cnt;
    l0 = long_cnt;
    first = 0;
    hold_btn(10);
    // release applied on this negedge; pulse expected 2 sync + 4 debounce + 1 action edges later
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (short_p && first == 0) first = i;
    end
    checks++;
    if (first !== 7) begin
      errors++;
      $display("FAIL short_latency: pulse at cycle %0d want 7", first);
    end
    idle(5);
    checks++;
    if (short_cnt - s0 !== 1 || long_cnt - l0 !== 0) begin
      errors++;
      $display("FAIL short_counts: short=%0d long=%0d want 1 0", short_cnt - s0, long_cnt - l0);
    end
    checks++;
    if (enable !== 1'b1 || rate !== 4'd5) begin
      errors++;
      $display("FAIL short_state: en=%b rate=%0d want en=1 rate=5", enable, rate);
    end
  endtask

  task automatic test_wrap;
    int s0;
    logic [3:0] want;
    for (int k = 6; k <= 15; k++) begin
      hold_btn(8);
      idle(14);
      want = 4'(k);
      checks++;
      if (rate !== want) begin
        errors++;
        $display("FAIL step_rate: got %0d want %0d", rate, want);
      end
    end
    hold_btn(8);
    idle(14);
    checks++;
    if (rate !== 4'd0 || enable !== 1'b1) begin
      errors++;
      $display("FAIL wrap_rate: rate=%0d en=%b want rate=0 en=1", rate, enable);
    end
    hold_btn(40);
    idle(20);
    checks++;
    if (enable !== 1'b0 || rate !== 4'd0) begin
      errors++;
      $display("FAIL disable: en=%b rate=%0d want en=0 rate=0", enable, rate);
    end
    s0 = short_cnt;
    hold_btn(8);
    idle(14);
    checks++;
    if (short_cnt - s0 !== 1 || rate !== 4'd0) begin
      errors++;
      $display("FAIL short_disabled: pulses=%0d rate=%0d want 1 and 0", short_cnt - s0, rate);
    end
  endtask

  task automatic test_glitch;
    int s0, l0;
    s0 = short_cnt;
    l0 = long_cnt;
    for (int r = 0; r < 2; r++) begin
      for (int w = 1; w <= 3; w++) begin
        hold_btn(w);
        idle(3);
      end
    end
    idle(10);
    checks++;
    if (short_cnt - s0 !== 0 || long_cnt - l0 !== 0) begin
      errors++;
      $display("FAIL glitch_pulses: short=%0d long=%0d want 0 0", short_cnt - s0, long_cnt - l0);
    end
    checks++;
    if (enable !== 1'b0 || rate !== 4'd0) begin
      errors++;
      $display("FAIL glitch_state: en=%b rate=%0d want en=0 rate=0", enable, rate);
    end
  endtask

  task automatic test_reset_mid;
    int s0, l0;
    hold_btn(40);
    idle(20);
    checks++;
    if (enable !== 1'b1 || rate !== 4'd0) begin
      errors++;
      $display("FAIL pre_reset_enable: en=%b rate=%0d want en=1 rate=0", enable, rate);
    end
    s0 = short_cnt;
    l0 = long_cnt;
    btn = 1'b1;
    idle(10);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (enable !== 1'b0 || rate !== 4'd4 || short_p !== 1'b0 || long_p !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: en=%b rate=%0d sp=%b lp=%b want en=0 rate=4 sp=0 lp=0",
               enable, rate, short_p, long_p);
    end
    idle(3);
    rst_n = 1'b1;
    idle(3);
    btn = 1'b0;
    idle(30);
    checks++;
    if (short_cnt - s0 !== 0 || long_cnt - l0 !== 0) begin
      errors++;
      $display("FAIL reset_mid_pulses: short=%0d long=%0d want 0 0", short_cnt - s0, long_cnt - l0);
    end
    checks++;
    if (enable !== 1'b0 || rate !== 4'd4) begin
      errors++;
      $display("FAIL reset_mid_state: en=%b rate=%0d want en=0 rate=4", enable, rate);
    end
    checks++;
    if (overlap_cnt !== 0) begin
      errors++;
      $display("FAIL pulse_overlap: got %0d cycles want 0", overlap_cnt);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    short_cnt   = 0;
    long_cnt    = 0;
    overlap_cnt = 0;
    rst_n       = 1'b0;
    btn         = 1'b0;
    test_reset();
    test_enable();
    test_short();
    test_wrap();
    test_glitch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
